// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: race FSM states, race result
// codes and the default debounce length.
package key_conditioner_pkg;

  localparam int DEBOUNCE_MS_DEFAULT = 10;

  typedef enum logic [1:0] {
    RACE_IDLE    = 2'd0,
    RACE_ARMED   = 2'd1,
    RACE_DECIDED = 2'd2
  } race_state_e;

  typedef enum logic [1:0] {
    FIRST_NONE = 2'b00,
    FIRST_P1   = 2'b01,
    FIRST_P2   = 2'b10,
    FIRST_TIE  = 2'b11
  } first_id_e;

  // Key 0 maps to bit 0 and key 3 to bit 1, so both pressed together gives TIE.
  function automatic first_id_e race_winner(input logic press0, input logic press3);
    return first_id_e'({press3, press0});
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, ms-tick debounce counter and
// registered press/release pulses.
module key_debounce
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic ms_tick,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sample;

  assign sample = ~sync2_q;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (ms_tick) begin
      // The level flips on the tick that completes the run; otherwise keep counting.
      if (cnt_q >= CNT_MAX) begin
        cnt_d     = '0;
        level_d   = sample;
        press_d   = sample;
        release_d = ~sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Four debounced push-buttons plus a race detector that reports whether key 0
// or key 3 was pressed first after an arm pulse.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ms_tick,
  input  logic [3:0] key_n,
  input  logic       arm,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic       first_valid,
  output logic [1:0] first_id
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
      ) u_key_debounce (
        .clk        (clk),
        .reset      (reset),
        .ms_tick    (ms_tick),
        .key_n      (key_n[gi]),
        .key_level  (key_level[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi])
      );
    end
  endgenerate

  race_state_e state_q, state_d;
  logic        first_valid_q, first_valid_d;
  first_id_e   first_id_q, first_id_d;

  always_comb begin
    state_d       = state_q;
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    // arm takes priority, so a press landing on the arm cycle never counts.
    if (arm) begin
      state_d       = RACE_ARMED;
      first_valid_d = 1'b0;
      first_id_d    = FIRST_NONE;
    end else begin
      case (state_q)
        RACE_ARMED: begin
          if (key_press[0] || key_press[3]) begin
            state_d       = RACE_DECIDED;
            first_valid_d = 1'b1;
            first_id_d    = race_winner(key_press[0], key_press[3]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RACE_IDLE;
      first_valid_q <= 1'b0;
      first_id_q    <= FIRST_NONE;
    end else begin
      state_q       <= state_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
    end
  end

  assign first_valid = first_valid_q;
  assign first_id    = first_id_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench: directed scenarios plus random key activity, all
// compared cycle-by-cycle against a behavioural model of the key conditioner.
module tb_key_conditioner;

  localparam int DB = 10;

  logic       clk;
  logic       reset;
  logic       ms_tick;
  logic [3:0] key_n;
  logic       arm;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       first_valid;
  logic [1:0] first_id;

  key_conditioner #(.DEBOUNCE_MS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .ms_tick    (ms_tick),
    .key_n      (key_n),
    .arm        (arm),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .first_valid(first_valid),
    .first_id   (first_id)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_div = 0;
  int tick_cnt = 0;
  int press_cnt [4];
  int rel_cnt [4];
  int last_press_cyc [4];
  int ticks_at_press [4];

  // Behavioural model state
  logic [3:0] m_s1, m_s2, m_level, m_press, m_rel;
  int         m_ticks [4];
  bit         m_waiting;
  logic       m_valid;
  logic [1:0] m_id;

  task automatic model_edge();
    logic [3:0] old_press;
    logic       sample;
    if (reset) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_level = 4'h0; m_press = 4'h0; m_rel = 4'h0;
      for (int k = 0; k < 4; k++) m_ticks[k] = 0;
      m_waiting = 1'b0; m_valid = 1'b0; m_id = 2'b00;
    end else begin
      old_press = m_press;
      if (arm) begin
        m_waiting = 1'b1; m_valid = 1'b0; m_id = 2'b00;
      end else if (m_waiting && (old_press[0] || old_press[3])) begin
        m_id = {old_press[3], old_press[0]};
        m_valid = 1'b1;
        m_waiting = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        sample = ~m_s2[k];
        m_press[k] = 1'b0;
        m_rel[k] = 1'b0;
        if (sample == m_level[k]) begin
          m_ticks[k] = 0;
        end else if (ms_tick) begin
          m_ticks[k] = m_ticks[k] + 1;
          if (m_ticks[k] == DB) begin
            m_level[k] = sample;
            m_ticks[k] = 0;
            m_press[k] = sample;
            m_rel[k] = ~sample;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  endtask

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // One clock: update model, compare all outputs, then gather counts and advance ms_tick.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if ({key_level, key_press, key_release, first_valid, first_id} !==
        {m_level, m_press, m_rel, m_valid, m_id}) begin
      failures++;
      $display("FAIL model_cmp cycle=%0d actual lvl=%b prs=%b rel=%b v=%b id=%b required lvl=%b prs=%b rel=%b v=%b id=%b",
               cyc, key_level, key_press, key_release, first_valid, first_id,
               m_level, m_press, m_rel, m_valid, m_id);
    end
    cyc++;
    if (ms_tick) tick_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (key_press[k] === 1'b1) begin
        press_cnt[k]++;
        last_press_cyc[k] = cyc;
        ticks_at_press[k] = tick_cnt;
      end
      if (key_release[k] === 1'b1) rel_cnt[k]++;
    end
    @(negedge clk);
    tick_div = (tick_div + 1) % 4;
    ms_tick = (tick_div == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; last_press_cyc[k] = -1; ticks_at_press[k] = -1;
    end
    tick_cnt = 0;
  endtask

  int mark;

  initial begin
    reset = 1'b1; ms_tick = 1'b0; key_n = 4'hF; arm = 1'b0;
    clear_counts();
    steps(3);
    chk("reset_level", int'(key_level), 0, 0);
    chk("reset_valid", int'(first_valid), 0, 0);
    chk("reset_id", int'(first_id), 0, 0);
    reset = 1'b0;
    steps(5);

    // Clean press on key 0
    clear_counts();
    key_n[0] = 1'b0;
    mark = cyc;
    steps(60);
    chk("clean_level0", int'(key_level[0]), 1, 1);
    chk("clean_press_cnt", press_cnt[0], 1, 1);
    chk("clean_latency", last_press_cyc[0] - mark, 38, 46);
    chk("clean_others", press_cnt[1] + press_cnt[2] + press_cnt[3] + rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0, 0);
    key_n = 4'hF;
    steps(60);

    // Bounce on key 3
    clear_counts();
    key_n[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      steps(8);
      key_n[3] = ~key_n[3];
    end
    mark = cyc;
    steps(60);
    chk("bounce_press_cnt", press_cnt[3], 1, 1);
    chk("bounce_latency", last_press_cyc[3] - mark, 38, 46);
    chk("bounce_level3", int'(key_level[3]), 1, 1);
    key_n = 4'hF;
    steps(60);

    // Race: key 3 then key 0
    arm = 1'b1; step(); arm = 1'b0;
    key_n[3] = 1'b0;
    steps(20);
    key_n[0] = 1'b0;
    steps(70);
    chk("race_valid", int'(first_valid), 1, 1);
    chk("race_id", int'(first_id), 2, 2);
    key_n = 4'hF;
    steps(60);

    // Tie
    arm = 1'b1; step(); arm = 1'b0;
    key_n[0] = 1'b0; key_n[3] = 1'b0;
    steps(60);
    chk("tie_valid", int'(first_valid), 1, 1);
    chk("tie_id", int'(first_id), 3, 3);
    key_n = 4'hF;
    steps(60);

    // Held key 0 before arm; key 3 pressed later wins
    key_n[0] = 1'b0;
    steps(60);
    arm = 1'b1; step(); arm = 1'b0;
    steps(30);
    chk("held_not_won", int'(first_valid), 0, 0);
    key_n[3] = 1'b0;
    steps(60);
    chk("held_id", int'(first_id), 2, 2);
    key_n = 4'hF;
    steps(60);

    // Reset mid-debounce on key 1
    clear_counts();
    key_n[1] = 1'b0;
    steps(28);
    chk("middeb_no_press", press_cnt[1], 0, 0);
    reset = 1'b1; step(); reset = 1'b0;
    tick_cnt = 0;
    steps(60);
    chk("middeb_press_cnt", press_cnt[1], 1, 1);
    chk("middeb_ticks", ticks_at_press[1], 10, 11);
    key_n = 4'hF;
    steps(60);

    // Random activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) key_n[$urandom_range(0, 3)] ^= 1'b1;
      arm = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 699) == 0);
      step();
    end
    arm = 1'b0; reset = 1'b0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
